// File: rtl/mod_n_ctr.sv
// Modulo-N counter with terminal-count flag and wrap pulse.
// Define MODN_CTR_CTRL_EN to add the enable, direction and load controls.
module mod_n_ctr #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned N     = 10
) (
    input  logic             clk,
    input  logic             rstn,
`ifdef MODN_CTR_CTRL_EN
    input  logic             en_i,
    input  logic             up_dn_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
`endif
    output logic [WIDTH-1:0] out_o,
    output logic             tc_o,
    output logic             wrap_o
);

    if (WIDTH < 1 || WIDTH > 31 || N < 2 || longint'(N) > (longint'(1) << WIDTH)) begin : gen_bad_cfg
        $error("mod_n_ctr: N=%0d illegal for WIDTH=%0d", N, WIDTH);
    end

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(N - 1);

    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;

`ifdef MODN_CTR_CTRL_EN
    assign en       = en_i;
    assign up_dn    = up_dn_i;
    assign load     = load_i;
    assign load_val = load_val_i;
`else
    assign en       = 1'b1;
    assign up_dn    = 1'b1;
    assign load     = 1'b0;
    assign load_val = '0;
`endif

    logic [WIDTH-1:0] out_q, out_d;

    always_comb begin
        out_d = out_q;
        if (load) begin
            // Out-of-range loads fall back to 0 so the count never leaves 0..N-1
            out_d = (load_val <= MaxVal) ? load_val : '0;
        end else if (en && up_dn) begin
            out_d = (out_q == MaxVal) ? '0 : out_q + WIDTH'(1);
        end else if (en) begin
            out_d = (out_q == '0) ? MaxVal : out_q - WIDTH'(1);
        end else begin
            out_d = out_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out_o  = out_q;
    assign tc_o   = up_dn ? (out_q == MaxVal) : (out_q == '0);
    assign wrap_o = tc_o & en & ~load;

endmodule

// File: tb/tb_mod_n_ctr.sv
// Scoreboarded bench for mod_n_ctr (N=10 main instance, N=8 all-ones boundary instance).
module tb_mod_n_ctr;

    localparam int W  = 4;
    localparam int NN = 10;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         en = 1'b1;
    logic         up_dn = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] out;
    logic         tc;
    logic         wrap;
    logic [2:0]   out8;
    logic         tc8;
    logic         wrap8;

    int tests = 0;
    int fails = 0;
    int m  = 0;
    int m8 = 0;
    int wraps8 = 0;
    int exp_q[$];
    int exp8_q[$];

    always #10 clk = ~clk;

`ifdef MODN_CTR_CTRL_EN
    mod_n_ctr #(.WIDTH(W), .N(NN)) dut (
        .clk(clk), .rstn(rstn), .en_i(en), .up_dn_i(up_dn), .load_i(load),
        .load_val_i(load_val), .out_o(out), .tc_o(tc), .wrap_o(wrap)
    );
    mod_n_ctr #(.WIDTH(3), .N(8)) dut8 (
        .clk(clk), .rstn(rstn), .en_i(1'b1), .up_dn_i(1'b1), .load_i(1'b0),
        .load_val_i(3'd0), .out_o(out8), .tc_o(tc8), .wrap_o(wrap8)
    );
`else
    mod_n_ctr #(.WIDTH(W), .N(NN)) dut (
        .clk(clk), .rstn(rstn), .out_o(out), .tc_o(tc), .wrap_o(wrap)
    );
    mod_n_ctr #(.WIDTH(3), .N(8)) dut8 (
        .clk(clk), .rstn(rstn), .out_o(out8), .tc_o(tc8), .wrap_o(wrap8)
    );
`endif

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: check combinational flags, queue expected next count, compare after edge.
    task automatic tick();
        int tc_e, wrap_e, nxt, nxt8, got;
        #1;
        tc_e   = up_dn ? int'(m == NN - 1) : int'(m == 0);
        wrap_e = (tc_e != 0 && en && !load) ? 1 : 0;
        check("tc", int'(tc), tc_e);
        check("wrap", int'(wrap), wrap_e);
        check("tc8", int'(tc8), int'(m8 == 7));
        check("wrap8", int'(wrap8), int'(m8 == 7));
        if (wrap8 === 1'b1) wraps8++;
        if (!rstn)      nxt = 0;
        else if (load)  nxt = (int'(load_val) < NN) ? int'(load_val) : 0;
        else if (!en)   nxt = m;
        else if (up_dn) nxt = (m + 1) % NN;
        else            nxt = (m + NN - 1) % NN;
        nxt8 = rstn ? (m8 + 1) % 8 : 0;
        exp_q.push_back(nxt);
        exp8_q.push_back(nxt8);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0 || exp8_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            got = exp_q.pop_front();
            check("out", int'(out), got);
            m = got;
            got = exp8_q.pop_front();
            check("out8", int'(out8), got);
            m8 = got;
        end
    endtask

`ifdef MODN_CTR_CTRL_EN
    task automatic do_load(input int v);
        load_val = W'(v);
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask
`endif

    initial begin
        int w0;
        // Reset held for two edges, then free run
        rstn = 1'b0;
        repeat (2) tick();
        check("reset_out", int'(out), 0);
        rstn = 1'b1;
        repeat (20) tick();
        check("after20_out", int'(out), 0);

        // Mid-count reset at out == 6
        for (int i = 0; i < 2 * NN && m != 6; i++) tick();
        check("pre_reset_out", int'(out), 6);
        rstn = 1'b0;
        tick();
        check("midreset_out", int'(out), 0);
        rstn = 1'b1;
        repeat (3) tick();
        check("resume_out", int'(out), 3);

        // Exactly two wrap pulses on the N=8 instance in any 16 cycles
        w0 = wraps8;
        repeat (16) tick();
        check("wrap8_count", wraps8 - w0, 2);

`ifdef MODN_CTR_CTRL_EN
        do_load(7);
        check("load7", int'(out), 7);
        do_load(12);
        check("load12", int'(out), 0);
        do_load(9);
        // Load with en at terminal count: load wins, no wrap
        do_load(3);
        check("load_over_en", int'(out), 3);
        do_load(2);
        up_dn = 1'b0;
        tick(); check("dn1", int'(out), 1);
        tick(); check("dn0", int'(out), 0);
        tick(); check("dn9", int'(out), 9);
        tick(); check("dn8", int'(out), 8);
        up_dn = 1'b1;
        do_load(4);
        en = 1'b0;
        repeat (5) tick();
        check("hold4", int'(out), 4);
        en = 1'b1;
        tick();
        check("resume5", int'(out), 5);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
